// File: rtl/iob_timer_mc_pkg.sv
// Shared register map and CTRL bit positions for the multi-channel timer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package iob_timer_mc_pkg;

    // Per-channel register offsets, selected by addr[2:0]
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_SAMPLE   = 3'd4,
        REG_VAL_LO   = 3'd5,
        REG_VAL_HI   = 3'd6,
        REG_STATUS   = 3'd7
    } reg_e;

    // CTRL register bit indices
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_SOFT_RST = 3;

endpackage

// File: rtl/iob_timer_mc_chan.sv
// One timer channel: prescaler, up-counter, compare, one-shot/periodic mode, sticky flag, sample register.
// Latency: register writes land at the sampling edge; irq is combinational from the flag register.
// Backpressure: none, every write strobe is consumed in the cycle it is presented.
//
// Ports: clk/rst (sync, active-high); *_we one-cycle write enables decoded by the top with the
// shared 32-bit wdata; en/periodic/irq_en/prescale/compare/sample/match_flag expose state for readback;
// irq = match_flag & irq_en.
module iob_timer_mc_chan
    import iob_timer_mc_pkg::*;
#(
    parameter int COUNT_W = 64,
    parameter int PRE_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_we,
    input  logic               pre_we,
    input  logic               cmp_lo_we,
    input  logic               cmp_hi_we,
    input  logic               sample_we,
    input  logic               status_we,
    input  logic [31:0]        wdata,
    output logic               en,
    output logic               periodic,
    output logic               irq_en,
    output logic [PRE_W-1:0]   prescale,
    output logic [COUNT_W-1:0] compare,
    output logic [COUNT_W-1:0] sample,
    output logic               match_flag,
    output logic               irq
);

    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nxt;
    logic [COUNT_W-1:0] compare_nxt;
    logic [COUNT_W-1:0] sample_nxt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [PRE_W-1:0]   pre_cnt_nxt;
    logic [PRE_W-1:0]   prescale_nxt;
    logic               en_nxt;
    logic               periodic_nxt;
    logic               irq_en_nxt;
    logic               flag_nxt;
    logic               tick;
    logic               hit;
    logic [63:0]        cmp64;

    assign tick = en && (pre_cnt == prescale);
    assign hit  = tick && (count == compare);
    assign irq  = match_flag & irq_en;

    always_comb begin
        en_nxt       = en;
        periodic_nxt = periodic;
        irq_en_nxt   = irq_en;
        pre_cnt_nxt  = pre_cnt;
        count_nxt    = count;
        flag_nxt     = match_flag;
        prescale_nxt = prescale;
        sample_nxt   = sample;
        cmp64        = 64'(compare);

        // Free-running operation
        if (en) begin
            if (tick) begin
                pre_cnt_nxt = '0;
                if (hit) begin
                    if (periodic) begin
                        count_nxt = '0;
                    end else begin
                        en_nxt = 1'b0;
                    end
                end else begin
                    count_nxt = count + COUNT_W'(1);
                end
            end else begin
                pre_cnt_nxt = pre_cnt + PRE_W'(1);
            end
        end

        // A match on the same edge as a W1C keeps the flag set
        if (hit) begin
            flag_nxt = 1'b1;
        end else if (status_we && wdata[0]) begin
            flag_nxt = 1'b0;
        end

        if (pre_we) begin
            prescale_nxt = PRE_W'(wdata);
        end

        // Compare halves are merged in a 64-bit view so narrow counters simply drop the high word
        if (cmp_lo_we) begin
            cmp64[31:0] = wdata;
        end
        if (cmp_hi_we) begin
            cmp64[63:32] = wdata;
        end
        compare_nxt = cmp64[COUNT_W-1:0];

        // Nonblocking capture of count yields the pre-tick value
        if (sample_we) begin
            sample_nxt = count;
        end

        // Software control overrides the run logic on the same edge
        if (ctrl_we) begin
            en_nxt       = wdata[CTRL_EN];
            periodic_nxt = wdata[CTRL_PERIODIC];
            irq_en_nxt   = wdata[CTRL_IRQ_EN];
            // Restart the prescaler on enable so the first tick is a full period away
            if (wdata[CTRL_EN] && !en) begin
                pre_cnt_nxt = '0;
            end
            if (wdata[CTRL_SOFT_RST]) begin
                count_nxt   = '0;
                pre_cnt_nxt = '0;
                flag_nxt    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            periodic   <= 1'b0;
            irq_en     <= 1'b0;
            pre_cnt    <= '0;
            count      <= '0;
            match_flag <= 1'b0;
            prescale   <= '0;
            compare    <= '1;
            sample     <= '0;
        end else begin
            en         <= en_nxt;
            periodic   <= periodic_nxt;
            irq_en     <= irq_en_nxt;
            pre_cnt    <= pre_cnt_nxt;
            count      <= count_nxt;
            match_flag <= flag_nxt;
            prescale   <= prescale_nxt;
            compare    <= compare_nxt;
            sample     <= sample_nxt;
        end
    end

endmodule

// File: rtl/iob_timer_mc.sv
// Multi-channel timer peripheral on the native slave bus: decode, read mux, ready/rdata, irq OR.
// Latency: ready and rdata one cycle after valid; writes take effect at the valid edge.
// Backpressure: none, every valid cycle is acknowledged exactly one cycle later.
//
// Ports: clk/rst (sync, active-high); valid/address/wdata/wstrb request (any wstrb bit = write);
// rdata/ready registered response; irq per-channel interrupt, irq_any OR of irq.
module iob_timer_mc
    import iob_timer_mc_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int COUNT_W = 64,
    parameter int PRE_W   = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = $clog2(N_CH) + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CH-1:0]     irq,
    output logic                irq_any
);

    logic               is_write;
    logic [31:0]        addr32;
    logic [28:0]        ch_sel;
    reg_e               reg_sel;
    logic [DATA_W-1:0]  rd_val;
    logic [63:0]        cmp64;
    logic [63:0]        smp64;

    logic [N_CH-1:0]    en_v;
    logic [N_CH-1:0]    periodic_v;
    logic [N_CH-1:0]    irq_en_v;
    logic [N_CH-1:0]    flag_v;
    logic [PRE_W-1:0]   prescale_v [N_CH];
    logic [COUNT_W-1:0] compare_v  [N_CH];
    logic [COUNT_W-1:0] sample_v   [N_CH];

    // Widening the address lets out-of-range channel indices fall through every decode
    assign is_write = |wstrb;
    assign addr32   = 32'(address);
    assign ch_sel   = addr32[31:3];
    assign reg_sel  = reg_e'(addr32[2:0]);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic wsel;
        assign wsel = valid && is_write && (ch_sel == 29'(c));

        iob_timer_mc_chan #(
            .COUNT_W (COUNT_W),
            .PRE_W   (PRE_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .ctrl_we    (wsel && (reg_sel == REG_CTRL)),
            .pre_we     (wsel && (reg_sel == REG_PRESCALE)),
            .cmp_lo_we  (wsel && (reg_sel == REG_CMP_LO)),
            .cmp_hi_we  (wsel && (reg_sel == REG_CMP_HI)),
            .sample_we  (wsel && (reg_sel == REG_SAMPLE)),
            .status_we  (wsel && (reg_sel == REG_STATUS)),
            .wdata      (wdata[31:0]),
            .en         (en_v[c]),
            .periodic   (periodic_v[c]),
            .irq_en     (irq_en_v[c]),
            .prescale   (prescale_v[c]),
            .compare    (compare_v[c]),
            .sample     (sample_v[c]),
            .match_flag (flag_v[c]),
            .irq        (irq[c])
        );
    end

    assign irq_any = |irq;

    // Read mux; zero-extension to 64 bits makes HI registers read 0 for narrow counters
    always_comb begin
        rd_val = '0;
        cmp64  = '0;
        smp64  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel == 29'(c)) begin
                cmp64 = 64'(compare_v[c]);
                smp64 = 64'(sample_v[c]);
                case (reg_sel)
                    REG_CTRL:     rd_val = {29'd0, irq_en_v[c], periodic_v[c], en_v[c]};
                    REG_PRESCALE: rd_val = 32'(prescale_v[c]);
                    REG_CMP_LO:   rd_val = cmp64[31:0];
                    REG_CMP_HI:   rd_val = cmp64[63:32];
                    REG_VAL_LO:   rd_val = smp64[31:0];
                    REG_VAL_HI:   rd_val = smp64[63:32];
                    REG_STATUS:   rd_val = {31'd0, flag_v[c]};
                    default:      rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            if (valid && !is_write) begin
                rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_iob_timer_mc.sv
module tb_iob_timer_mc;

    localparam int R_CTRL = 0, R_PRE = 1, R_CMPLO = 2, R_CMPHI = 3;
    localparam int R_SAMPLE = 4, R_VALLO = 5, R_VALHI = 6, R_STATUS = 7;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [3:0]  irq;
    logic        irq_any;

    iob_timer_mc dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready),
        .irq     (irq),
        .irq_any (irq_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (register-level view of each channel) ----------------
    bit               m_en   [4];
    bit               m_per  [4];
    bit               m_ie   [4];
    bit               m_flag [4];
    int unsigned      m_pre  [4];
    int unsigned      m_ps   [4];
    longint unsigned  m_cnt  [4];
    longint unsigned  m_cmp  [4];
    longint unsigned  m_smp  [4];
    logic [31:0]      m_last;

    typedef struct {
        bit          is_rd;
        logic [31:0] dat;
        bit          has_dir;
        logic [31:0] dir;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    bit              dir_use;
    logic [31:0]     dir_val;
    string           dir_name;
    bit              bd_pend;
    longint unsigned bd_val;
    bit              mon_en;

    function automatic logic [31:0] m_read(input int c, input int r);
        case (r)
            R_CTRL:   return {29'd0, m_ie[c], m_per[c], m_en[c]};
            R_PRE:    return m_ps[c];
            R_CMPLO:  return 32'(m_cmp[c]);
            R_CMPHI:  return 32'(m_cmp[c] >> 32);
            R_VALLO:  return 32'(m_smp[c]);
            R_VALHI:  return 32'(m_smp[c] >> 32);
            R_STATUS: return {31'd0, m_flag[c]};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] m_irq();
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_flag[c] & m_ie[c];
        return v;
    endfunction

    initial begin : model
        int  bch, br;
        bit  wr, tick, hit, n_en, n_flag;
        int unsigned     n_pre;
        longint unsigned n_cnt;
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int c = 0; c < 4; c++) begin
                    m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
                    m_pre[c] = 0; m_ps[c] = 0; m_cnt[c] = 0; m_smp[c] = 0;
                    m_cmp[c] = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                m_last = 32'd0;
                exp_q.delete();
            end else begin
                bch = int'(address[4:3]);
                br  = int'(address[2:0]);
                wr  = |wstrb;
                if (valid) begin
                    if (!wr) m_last = m_read(bch, br);
                    e.is_rd   = !wr;
                    e.dat     = m_last;
                    e.has_dir = dir_use && !wr;
                    e.dir     = dir_val;
                    e.nm      = dir_name;
                    exp_q.push_back(e);
                end
                for (int c = 0; c < 4; c++) begin
                    tick   = m_en[c] && (m_pre[c] == m_ps[c]);
                    hit    = tick && (m_cnt[c] == m_cmp[c]);
                    n_en   = m_en[c];
                    n_pre  = m_pre[c];
                    n_cnt  = m_cnt[c];
                    n_flag = m_flag[c];
                    if (m_en[c]) begin
                        if (!tick) n_pre = (m_pre[c] + 1) & 32'hFFFF;
                        else begin
                            n_pre = 0;
                            if (hit) begin
                                n_flag = 1;
                                if (m_per[c]) n_cnt = 0;
                                else n_en = 0;
                            end else n_cnt = m_cnt[c] + 1;
                        end
                    end
                    if (valid && wr && bch == c) begin
                        case (br)
                            R_CTRL: begin
                                if (wdata[0] && !m_en[c]) n_pre = 0;
                                n_en = wdata[0]; m_per[c] = wdata[1]; m_ie[c] = wdata[2];
                                if (wdata[3]) begin n_cnt = 0; n_pre = 0; n_flag = 0; end
                            end
                            R_PRE:    m_ps[c] = 32'(wdata[15:0]);
                            R_CMPLO:  m_cmp[c] = (m_cmp[c] & 64'hFFFF_FFFF_0000_0000) | 64'(wdata);
                            R_CMPHI:  m_cmp[c] = (m_cmp[c] & 64'h0000_0000_FFFF_FFFF) | (64'(wdata) << 32);
                            R_SAMPLE: m_smp[c] = m_cnt[c];
                            R_STATUS: if (wdata[0] && !hit) n_flag = 0;
                            default: ;
                        endcase
                    end
                    if (bd_pend && c == 2) n_cnt = bd_val;
                    m_en[c] = n_en; m_pre[c] = n_pre; m_cnt[c] = n_cnt; m_flag[c] = n_flag;
                end
                bd_pend = 0;
            end
        end
    end

    // ---------------- monitor: pops an expectation whenever the DUT acknowledges ----------------
    initial begin : monitor
        bit   want;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                want = (exp_q.size() != 0);
                chk("ready", 64'(ready), 64'(want));
                if (want) begin
                    e = exp_q.pop_front();
                    chk(e.is_rd ? "rdata" : "rdata_hold", 64'(rdata), 64'(e.dat));
                    if (e.has_dir) chk(e.nm, 64'(rdata), 64'(e.dir));
                end
                chk("irq", 64'(irq), 64'(m_irq()));
                chk("irq_any", 64'(irq_any), 64'(|m_irq()));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        valid   = 1'b1;
        address = {ch[1:0], r[2:0]};
        wdata   = d;
        wstrb   = 4'($urandom_range(1, 15));
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'd0;
    endtask

    task automatic bus_read(input int ch, input int r, input bit use_dir,
                            input logic [31:0] dv, input string nm);
        dir_use  = use_dir;
        dir_val  = dv;
        dir_name = nm;
        valid    = 1'b1;
        address  = {ch[1:0], r[2:0]};
        wdata    = $urandom;
        wstrb    = 4'd0;
        @(posedge clk);
        @(negedge clk);
        valid   = 1'b0;
        dir_use = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int found, c, r;
        logic [31:0] d;
        rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
        dir_use = 0; dir_val = '0; dir_name = ""; bd_pend = 0; bd_val = 0; mon_en = 0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: reset state
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        bus_read(0, R_CMPLO, 1, 32'hFFFF_FFFF, "ch0_cmp_lo_reset");
        bus_read(0, R_CMPHI, 1, 32'hFFFF_FFFF, "ch0_cmp_hi_reset");
        bus_read(0, R_CTRL,  1, 32'h0, "ch0_ctrl_reset");

        // 2: ch1 periodic with prescaler 2 and compare 5 -> match every 18 cycles
        bus_write(1, R_PRE, 2);
        bus_write(1, R_CMPLO, 5);
        bus_write(1, R_CMPHI, 0);
        bus_write(1, R_CTRL, 32'h7);
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (irq[1]) begin found = k; break; end
        end
        chk("irq1_first_rise_cycles", 64'(found), 64'd18);
        bus_write(1, R_STATUS, 32'h1);
        chk("irq1_after_w1c", 64'(irq[1]), 64'd0);
        found = 0;
        for (int k = 2; k <= 41; k++) begin
            @(negedge clk);
            if (irq[1]) begin found = k; break; end
        end
        chk("irq1_second_rise_cycles", 64'(found), 64'd18);

        // 5: W1C on the same edge as the next match; set wins
        idle(17);
        bus_write(1, R_STATUS, 32'h1);
        chk("coincident_irq_any", 64'(irq_any), 64'd1);
        chk("coincident_irq1", 64'(irq[1]), 64'd1);
        bus_read(1, R_STATUS, 1, 32'h1, "coincident_status");
        bus_write(1, R_CTRL, 32'h8);

        // 3: ch0 one-shot, prescaler 0, compare 3
        bus_write(0, R_PRE, 0);
        bus_write(0, R_CMPLO, 3);
        bus_write(0, R_CMPHI, 0);
        bus_write(0, R_CTRL, 32'h5);
        idle(6);
        bus_read(0, R_CTRL, 1, 32'h4, "oneshot_ctrl");
        bus_read(0, R_STATUS, 1, 32'h1, "oneshot_status");
        bus_write(0, R_SAMPLE, 0);
        bus_read(0, R_VALLO, 1, 32'd3, "oneshot_val_lo");
        bus_read(0, R_VALHI, 1, 32'd0, "oneshot_val_hi");
        idle(5);
        bus_write(0, R_SAMPLE, 0);
        bus_read(0, R_VALLO, 1, 32'd3, "oneshot_val_lo_stable");

        // 4: ch2 64-bit carry across bit 32, count preloaded via the next-state net
        bus_write(2, R_CTRL, 32'h8);
        bus_write(2, R_PRE, 0);
        bus_write(2, R_CMPLO, 32'hFFFF_FFFF);
        bus_write(2, R_CMPHI, 32'hFFFF_FFFF);
        force dut.g_ch[2].u_chan.count_nxt = 64'h0000_0000_FFFF_FFFE;
        bd_val  = 64'h0000_0000_FFFF_FFFE;
        bd_pend = 1'b1;
        @(posedge clk);
        @(negedge clk);
        release dut.g_ch[2].u_chan.count_nxt;
        bus_write(2, R_CTRL, 32'h1);
        bus_write(2, R_SAMPLE, 0);
        bus_read(2, R_VALLO, 1, 32'hFFFF_FFFE, "carry_pre_val_lo");
        bus_read(2, R_VALHI, 1, 32'h0, "carry_pre_val_hi");
        idle(2);
        bus_write(2, R_SAMPLE, 0);
        bus_read(2, R_VALHI, 1, 32'h1, "carry_val_hi");
        bus_read(2, R_VALLO, 1, 32'h3, "carry_val_lo");

        // 6a: soft reset of a running channel
        bus_write(3, R_PRE, 0);
        bus_write(3, R_CTRL, 32'h1);
        idle(20);
        bus_write(3, R_CTRL, 32'h9);
        bus_write(3, R_SAMPLE, 0);
        bus_read(3, R_VALLO, 1, 32'h0, "softrst_val_lo");
        bus_read(3, R_VALHI, 1, 32'h0, "softrst_val_hi");

        // Randomised register traffic against the model
        for (int i = 0; i < 300; i++) begin
            c = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 7));
            case (r)
                R_CTRL:  d = $urandom_range(0, 15);
                R_PRE:   d = $urandom_range(0, 3);
                R_CMPLO: d = $urandom_range(0, 24);
                R_CMPHI: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) bus_write(c, r, d);
            else bus_read(c, r, 0, 32'h0, "");
            idle(int'($urandom_range(0, 2)));
        end

        // 6b: reset asserted with a request in flight
        rst     = 1'b1;
        valid   = 1'b1;
        address = 5'd0;
        wstrb   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        rst   = 1'b0;
        valid = 1'b0;
        bus_read(0, R_CTRL,   1, 32'h0, "post_rst_ctrl0");
        bus_read(1, R_STATUS, 1, 32'h0, "post_rst_status1");
        bus_read(2, R_CMPHI,  1, 32'hFFFF_FFFF, "post_rst_cmp_hi2");
        bus_read(3, R_PRE,    1, 32'h0, "post_rst_pre3");
        bus_read(2, R_VALLO,  1, 32'h0, "post_rst_val_lo2");
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
